// File: rtl/cnt_arb_pkg.sv
// Shared types and defaults for the arbitrated shared counter (cnt_share_arb).
package cnt_arb_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Round-robin successor of a granted index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arb_pick
  import cnt_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx,
  output logic            valid
);

  // Scan NREQ positions starting at ptr; only the first hit is taken.
  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int  idx;
      logic hit;
      idx = int'(ptr) + k;
      idx = (idx >= NREQ) ? idx - NREQ : idx;
      hit = req[idx] & ~valid;
      win[idx] = win[idx] | hit;
      win_idx  = hit ? PW'(idx) : win_idx;
      valid    = valid | hit;
    end
  end

endmodule

// File: rtl/cnt_share_arb.sv
// Round-robin arbitrated shared counter. Optional tenure limit enabled by
// defining CNT_SHARE_ARB_TIMEOUT_EN (MAX_HOLD cycles per grant).
module cnt_share_arb
  import cnt_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  inc,
  input  logic [NREQ-1:0]  clr,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             busy
);

  localparam int PW = $clog2(NREQ);

  arb_state_e      state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic            wrap_nxt;
  logic            busy_nxt;

  logic [NREQ-1:0] pick_win;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;

`ifdef CNT_SHARE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(MAX_HOLD + 1);
  logic [TW-1:0] tenure, tenure_nxt;
`endif

  rr_arb_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  // Next-state: arbitration, owner commands and tenure limit.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
`ifdef CNT_SHARE_ARB_TIMEOUT_EN
    tenure_nxt = '0;
`endif
    case (state)
      ST_IDLE, ST_RELEASE: begin
        if (pick_valid) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = pick_win;
          owner_nxt = pick_idx;
          ptr_nxt   = PW'(rr_next(int'(pick_idx), NREQ));
`ifdef CNT_SHARE_ARB_TIMEOUT_EN
          tenure_nxt = TW'(1'b1);
`endif
        end else begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        // A dropping request ends tenure and any command with it is ignored.
        if (!req[owner]) begin
          state_nxt = ST_RELEASE;
          gnt_nxt   = '0;
        end else begin
          if (clr[owner]) begin
            cnt_nxt = '0;
          end else if (inc[owner]) begin
            cnt_nxt  = cnt + WIDTH'(1'b1);
            wrap_nxt = &cnt;
          end else begin
            cnt_nxt = cnt;
          end
`ifdef CNT_SHARE_ARB_TIMEOUT_EN
          if (tenure >= TW'(MAX_HOLD)) begin
            state_nxt  = ST_RELEASE;
            gnt_nxt    = '0;
            tenure_nxt = '0;
          end else begin
            tenure_nxt = tenure + TW'(1'b1);
          end
`else
          // Unlimited tenure: only a dropped request ends ownership.
`endif
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
    busy_nxt = |gnt_nxt;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
      gnt   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      gnt   <= gnt_nxt;
      cnt   <= cnt_nxt;
      wrap  <= wrap_nxt;
      busy  <= busy_nxt;
    end
  end

`ifdef CNT_SHARE_ARB_TIMEOUT_EN
  // Grant tenure counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tenure <= '0;
    end else begin
      tenure <= tenure_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_cnt_share_arb.sv
// Scoreboard bench for cnt_share_arb: directed vectors push expectations,
// an independent monitor pops and compares one entry per clock.
module tb_cnt_share_arb;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] inc = 4'b0;
  logic [3:0] clr = 4'b0;
  logic [3:0] gnt;
  logic [7:0] cnt;
  logic       wrap;
  logic       busy;

  typedef struct {
    string      nm;
    logic [13:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  cnt_share_arb #(.NREQ(4), .WIDTH(8), .MAX_HOLD(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .req  (req),
    .inc  (inc),
    .clr  (clr),
    .gnt  (gnt),
    .cnt  (cnt),
    .wrap (wrap),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [13:0] got, input logic [13:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got gnt=%b cnt=%h wrap=%b busy=%b, want gnt=%b cnt=%h wrap=%b busy=%b",
               nm, got[13:10], got[9:2], got[1], got[0], exp[13:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Drive one vector at the falling edge; expectation applies after the next rising edge.
  task automatic step(input string nm, input logic rv, input logic [3:0] rq, input logic [3:0] ic,
                      input logic [3:0] cl, input logic [3:0] eg, input logic [7:0] ec, input logic ew);
    exp_t e;
    @(negedge clk);
    rstn = rv;
    req  = rq;
    inc  = ic;
    clr  = cl;
    e.nm  = nm;
    e.val = {eg, ec, ew, |eg};
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check(mon_e.nm, {gnt, cnt, wrap, busy}, mon_e.val);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] own;
    logic [3:0] nxt;
    #3;
    check("reset_state", {gnt, cnt, wrap, busy}, 14'b0);
    step("rst_hold", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
    step("idle_noreq", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);

    // Single requester, three owner increments.
    step("grant_r0", 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'h00, 1'b0);
    step("inc1", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'h01, 1'b0);
    step("inc2", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'h02, 1'b0);
    step("inc3", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'h03, 1'b0);
    step("drop_r0", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h03, 1'b0);
    step("idle_hold", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h03, 1'b0);

    // Reset to ptr=0, then two requesters with handover through a dead cycle.
    step("rst_ptr", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
    step("rr_1010", 1'b1, 4'b1010, 4'b0000, 4'b0000, 4'b0010, 8'h00, 1'b0);
    step("r1_inc", 1'b1, 4'b1010, 4'b0010, 4'b0000, 4'b0010, 8'h01, 1'b0);
    step("r1_drop_cmd", 1'b1, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 8'h01, 1'b0);
    step("regrant_r3", 1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 8'h01, 1'b0);

    // Count up to FE, then wrap.
    for (int k = 2; k <= 254; k++)
      step("ramp", 1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 8'(k), 1'b0);
    step("to_ff", 1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 8'hFF, 1'b0);
    step("wrap_00", 1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 8'h00, 1'b1);
    step("wrap_end", 1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 8'h00, 1'b0);

    // Non-owner commands ignored, clr beats inc.
    for (int k = 1; k <= 16; k++)
      step("nonown_inc", 1'b1, 4'b1000, 4'b1111, 4'b0000, 4'b1000, 8'(k), 1'b0);
    step("clr_wins", 1'b1, 4'b1000, 4'b1111, 4'b1000, 4'b1000, 8'h00, 1'b0);
    step("inc_after_clr", 1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 8'h01, 1'b0);
    step("nonown_clr", 1'b1, 4'b1000, 4'b0000, 4'b0111, 4'b1000, 8'h01, 1'b0);
    step("drop_r3", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h01, 1'b0);
    step("idle_r3", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h01, 1'b0);

    // Reset mid-tenure with cnt=25.
    step("grant_r0b", 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'h01, 1'b0);
    for (int k = 2; k <= 37; k++)
      step("ramp25", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'(k), 1'b0);
    step("rst_mid", 1'b0, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0);
    #1;
    check("rst_immediate", {gnt, cnt, wrap, busy}, 14'b0);
    step("post_rst_grant", 1'b1, 4'b0110, 4'b0110, 4'b0000, 4'b0010, 8'h00, 1'b0);
    step("drop_r1", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
    step("idle_r1", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);

    // Tenure behaviour with two persistent requesters (ptr=2 here).
    step("hold_grant", 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 8'h00, 1'b0);
`ifdef CNT_SHARE_ARB_TIMEOUT_EN
    for (int r = 0; r < 3; r++) begin
      own = (r % 2 == 0) ? 4'b0001 : 4'b0010;
      nxt = (r % 2 == 0) ? 4'b0010 : 4'b0001;
      repeat (15) step("tenure", 1'b1, 4'b0011, 4'b0000, 4'b0000, own, 8'h00, 1'b0);
      step("timeout_dead", 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
      step("timeout_next", 1'b1, 4'b0011, 4'b0000, 4'b0000, nxt, 8'h00, 1'b0);
    end
`else
    own = 4'b0001;
    nxt = 4'b0001;
    repeat (40) step("unlimited", 1'b1, 4'b0011, 4'b0000, 4'b0000, own, 8'h00, 1'b0);
`endif
    step("final_drop", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
    step("final_idle", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);

    for (int w = 0; w < 5 && sb.size() != 0; w++) @(posedge clk);
    #3;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
